// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port word RAM between the fetch port and the load/store port.
// Optional MEM_ARB_ALIGN_CHECK_EN: misaligned requests are blocked and answered with DEADBEEF plus align_err.
module mem_port_arbiter #(
    parameter int MEM_WORDS  = 128,
    parameter int STARVE_MAX = 4,
    localparam int AW = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [31:0]   i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [31:0]   i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
`ifdef MEM_ARB_ALIGN_CHECK_EN
    output logic          align_err,
`endif
    input  logic [31:0]   mem_rdata
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_I    = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;

    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic [1:0]    owner_q, owner_d;
    logic [31:0]   i_rdata_q, i_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
    logic [31:0]   sel_addr;
    logic [31:0]   resp_data;
    logic          any_gnt;
    logic          misaligned;
`ifdef MEM_ARB_ALIGN_CHECK_EN
    logic          err_q, err_d;
`endif

    // Address bits outside the word index never reach the memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[31:AW+2], d_addr[31:AW+2], i_addr[1:0], d_addr[1:0]};

    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        // Data port wins unless the fetch has been starved STARVE_MAX times in a row.
        if (!reset) begin
            if (i_req && (!d_req || starve_cnt_q == CW'(STARVE_MAX))) begin
                i_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end
        any_gnt  = i_gnt | d_gnt;
        sel_addr = i_gnt ? i_addr : d_addr;
`ifdef MEM_ARB_ALIGN_CHECK_EN
        misaligned = any_gnt && (sel_addr[1:0] != 2'b00);
        err_d      = misaligned;
`else
        misaligned = 1'b0;
`endif
        mem_en    = any_gnt && !misaligned;
        mem_we    = mem_en && d_gnt && d_we;
        mem_addr  = mem_en ? sel_addr[AW+1:2] : '0;
        mem_wdata = mem_en ? d_wdata : '0;

        starve_cnt_d = starve_cnt_q;
        if (i_gnt || !i_req) begin
            starve_cnt_d = '0;
        end else if (d_gnt && starve_cnt_q != CW'(STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
        end

        if (i_gnt) begin
            owner_d = OWN_I;
        end else if (d_gnt && !d_we) begin
            owner_d = OWN_D;
        end else begin
            owner_d = OWN_NONE;
        end

`ifdef MEM_ARB_ALIGN_CHECK_EN
        resp_data = err_q ? 32'hDEADBEEF : mem_rdata;
        align_err = !reset && err_q;
`else
        resp_data = mem_rdata;
`endif
        // Response stage: only the owning port sees memory data, the other keeps its last word.
        i_rvalid  = !reset && (owner_q == OWN_I);
        d_rvalid  = !reset && (owner_q == OWN_D);
        i_rdata   = i_rvalid ? resp_data : i_rdata_q;
        d_rdata   = d_rvalid ? resp_data : d_rdata_q;
        i_rdata_d = i_rdata;
        d_rdata_d = d_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= '0;
            owner_q      <= OWN_NONE;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
            err_q        <= 1'b0;
`endif
        end else begin
            starve_cnt_q <= starve_cnt_d;
            owner_q      <= owner_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
`ifdef MEM_ARB_ALIGN_CHECK_EN
            err_q        <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a behavioural model, plus directed literal checks.
// Honours MEM_ARB_ALIGN_CHECK_EN when the design is built with it.
module tb_mem_port_arbiter;

    localparam int MEM_WORDS  = 128;
    localparam int STARVE_MAX = 4;
    localparam int AW         = $clog2(MEM_WORDS);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_req = 1'b0;
    logic [31:0]   i_addr = '0;
    logic          i_gnt, i_rvalid;
    logic [31:0]   i_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [31:0]   d_addr = '0;
    logic [31:0]   d_wdata = '0;
    logic          d_gnt, d_rvalid;
    logic [31:0]   d_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = '0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
    logic          align_err;
`endif

    int checks = 0;
    int failures = 0;

    logic [31:0] ram [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];

    mem_port_arbiter #(.MEM_WORDS(MEM_WORDS), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef MEM_ARB_ALIGN_CHECK_EN
        .align_err(align_err),
`endif
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Environment RAM: writes land at the edge, reads return one cycle later.
    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model state
    int          cnt = 0;
    bit          pend_i = 0, pend_d = 0, pend_err = 0;
    logic [31:0] pend_data = '0, last_i = '0, last_d = '0;

    always @(negedge clk) begin
        logic [31:0] exp_i, exp_d, ga, rd;
        bit gi, gd, mis, e_en;
        int idx;
        if (reset) begin
            chk("rst_i_gnt", 32'(i_gnt), 32'd0);
            chk("rst_d_gnt", 32'(d_gnt), 32'd0);
            chk("rst_mem_en", 32'(mem_en), 32'd0);
            chk("rst_i_rvalid", 32'(i_rvalid), 32'd0);
            chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
`ifdef MEM_ARB_ALIGN_CHECK_EN
            chk("rst_align_err", 32'(align_err), 32'd0);
`endif
            cnt = 0; pend_i = 0; pend_d = 0; pend_err = 0; last_i = '0; last_d = '0;
        end else begin
            exp_i = pend_i ? pend_data : last_i;
            exp_d = pend_d ? pend_data : last_d;
            chk("i_rvalid", 32'(i_rvalid), 32'(pend_i));
            chk("d_rvalid", 32'(d_rvalid), 32'(pend_d));
            chk("i_rdata", i_rdata, exp_i);
            chk("d_rdata", d_rdata, exp_d);
`ifdef MEM_ARB_ALIGN_CHECK_EN
            chk("align_err", 32'(align_err), 32'(pend_err));
`endif
            last_i = exp_i;
            last_d = exp_d;

            gi = i_req && (!d_req || cnt >= STARVE_MAX);
            gd = d_req && !gi;
            ga = gi ? i_addr : d_addr;
`ifdef MEM_ARB_ALIGN_CHECK_EN
            mis = (gi || gd) && (ga % 4 != 0);
`else
            mis = 0;
`endif
            idx  = int'((ga / 4) % 32'(MEM_WORDS));
            e_en = (gi || gd) && !mis;
            chk("i_gnt", 32'(i_gnt), 32'(gi));
            chk("d_gnt", 32'(d_gnt), 32'(gd));
            chk("mem_en", 32'(mem_en), 32'(e_en));
            chk("mem_we", 32'(mem_we), 32'(e_en && gd && d_we));
            chk("mem_addr", 32'(mem_addr), e_en ? 32'(idx) : 32'd0);
            chk("mem_wdata", mem_wdata, e_en ? d_wdata : 32'd0);

            rd = mis ? 32'hDEADBEEF : ref_mem[idx];
            pend_i = gi;
            pend_d = gd && !d_we;
            pend_data = rd;
            pend_err = mis;
            if (e_en && gd && d_we) ref_mem[idx] = d_wdata;
            if (gi || !i_req) cnt = 0;
            else if (gd) cnt = (cnt + 1 > STARVE_MAX) ? STARVE_MAX : cnt + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                         input logic [31:0] da, input logic [31:0] dd);
        i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    endtask

    logic [31:0] words [3];
    bit ig_s, dg_s;

    initial begin
        words[0] = 32'hE3A000AA; words[1] = 32'hE3A01055; words[2] = 32'hE3A020FF;
        for (int w = 0; w < MEM_WORDS; w++) begin
            ram[w] = (w < 3) ? words[w] : $urandom;
            ref_mem[w] = ram[w];
        end

        // Reset held with both requests pending
        drive(1, 32'h0, 1, 0, 32'h10, 32'h0);
        for (int k = 0; k < 2; k++) begin
            step(); #3;
            chk("reset_i_gnt", 32'(i_gnt), 32'd0);
            chk("reset_d_gnt", 32'(d_gnt), 32'd0);
        end
        step(); reset = 1'b0; #3;
        chk("first_grant_d", 32'({i_gnt, d_gnt}), 32'b01);

        // Fetch-only stream
        for (int k = 0; k < 4; k++) begin
            step();
            drive(k < 3, 32'(4 * k), 0, 0, 32'h0, 32'h0);
            #3;
            if (k < 3) chk("fetch_gnt", 32'(i_gnt), 32'd1);
            if (k > 0) begin
                chk("fetch_rvalid", 32'(i_rvalid), 32'd1);
                chk("fetch_rdata", i_rdata, words[k-1]);
            end
        end

        // Store then load same word
        step(); drive(0, 32'h0, 1, 1, 32'hFC, 32'h12345678); #3;
        chk("store_gnt", 32'(d_gnt), 32'd1);
        chk("store_mem_we", 32'(mem_we), 32'd1);
        chk("store_mem_addr", 32'(mem_addr), 32'd63);
        step(); drive(0, 32'h0, 1, 0, 32'hFC, 32'h0); #3;
        chk("no_rvalid_after_store", 32'(d_rvalid), 32'd0);
        step(); drive(0, 32'h0, 0, 0, 32'h0, 32'h0); #3;
        chk("load_rvalid", 32'(d_rvalid), 32'd1);
        chk("load_rdata", d_rdata, 32'h12345678);

        // Starvation: D,D,D,D,I repeating
        for (int k = 0; k < 15; k++) begin
            step(); drive(1, 32'h4, 1, 0, 32'(4 * $urandom_range(3, 20)), 32'h0); #3;
            chk("starve_i_gnt", 32'(i_gnt), 32'(k % 5 == 4));
            chk("starve_i_rvalid", 32'(i_rvalid), 32'(k % 5 == 0 && k > 0));
        end

        // Address wrap
        step(); drive(1, 32'h200, 0, 0, 32'h0, 32'h0); #3;
        chk("wrap_mem_addr", 32'(mem_addr), 32'd0);
        chk("wrap_mem_en", 32'(mem_en), 32'd1);
        step(); drive(0, 32'h0, 0, 0, 32'h0, 32'h0); #3;
        chk("wrap_rdata", i_rdata, 32'hE3A000AA);

`ifdef MEM_ARB_ALIGN_CHECK_EN
        step(); drive(0, 32'h0, 1, 0, 32'h6, 32'h0); #3;
        chk("align_gnt", 32'(d_gnt), 32'd1);
        chk("align_mem_en", 32'(mem_en), 32'd0);
        step(); drive(0, 32'h0, 0, 0, 32'h0, 32'h0); #3;
        chk("align_rvalid", 32'(d_rvalid), 32'd1);
        chk("align_rdata", d_rdata, 32'hDEADBEEF);
        chk("align_err_pulse", 32'(align_err), 32'd1);
`endif

        // Random traffic with requests held until granted and occasional mid-run reset
        ig_s = 0; dg_s = 0;
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ra, rb;
            step();
            if (!i_req || ig_s) i_req = ($urandom_range(0, 2) != 0);
            if (!d_req || dg_s) d_req = ($urandom_range(0, 2) != 0);
            ra = {$urandom_range(0, 3) == 0 ? 23'($urandom) : 23'd0, 7'($urandom_range(0, 7)), 2'b00};
            rb = {$urandom_range(0, 3) == 0 ? 23'($urandom) : 23'd0, 7'($urandom_range(0, 7)), 2'b00};
`ifdef MEM_ARB_ALIGN_CHECK_EN
            if ($urandom_range(0, 7) == 0) ra[1:0] = 2'($urandom);
            if ($urandom_range(0, 7) == 0) rb[1:0] = 2'($urandom);
`endif
            i_addr  = ra;
            d_addr  = rb;
            d_we    = $urandom_range(0, 1) == 1;
            d_wdata = $urandom;
            reset   = ($urandom_range(0, 199) == 0);
            #3;
            ig_s = i_gnt;
            dg_s = d_gnt;
        end

        step(); reset = 1'b0; drive(0, 32'h0, 0, 0, 32'h0, 32'h0);
        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, word-addressed unified memory between the processor's instruction-fetch port and its load/store data port.
- Grants at most one requester per cycle, drives the memory, and routes the 1-cycle-latency read data back to the granted requester.
- Data port has priority; a starvation counter guarantees fetch progress.
- Sits between the ARM core and the program/data RAM in the multicycle/pipelined variants.

Parameters:
- MEM_WORDS, 128, memory depth in 32-bit words; index width AW = $clog2(MEM_WORDS).
- STARVE_MAX, 4, maximum consecutive data grants while a fetch is pending; the next arbitrated cycle forces a fetch grant.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- i_req  input  1  fetch request, held until granted.
- i_addr  input  32  fetch byte address.
- i_gnt  output  1  fetch accepted this cycle (combinational).
- i_rvalid  output  1  fetch read data valid.
- i_rdata  output  32  fetch read data.
- d_req  input  1  data request, held until granted.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  32  data byte address.
- d_wdata  input  32  store data.
- d_gnt  output  1  data access accepted this cycle (combinational).
- d_rvalid  output  1  load data valid; never asserted for stores.
- d_rdata  output  32  load data.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write enable.
- mem_addr  output  AW  word index.
- mem_wdata  output  32  memory write data.
- mem_rdata  input  32  memory read data, valid the cycle after mem_en with mem_we = 0.

Behaviour:
- Reset values: i_rvalid = d_rvalid = 0; starve_cnt = 0; owner = NONE; i_rdata = d_rdata = 0.
- Reset applied mid-operation drops any in-flight read response; no rvalid follows.
- Arbitration each cycle (combinational from requests and starve_cnt):
  - only d_req: grant D.
  - only i_req: grant I.
  - both, starve_cnt < STARVE_MAX: grant D.
  - both, starve_cnt == STARVE_MAX: grant I.
- Exactly one of i_gnt and d_gnt is high when any request is present; neither is high with no request.
- Memory drive:
  - mem_en = i_gnt | d_gnt.
  - mem_we = d_gnt & d_we.
  - mem_addr = granted addr[AW+1:2]; upper bits ignored, so addresses wrap modulo MEM_WORDS.
  - mem_wdata = d_wdata.
  - When no grant, mem_en = 0 and all other memory outputs are 0.
- starve_cnt:
  - increments (saturating at STARVE_MAX) on a D grant while i_req = 1.
  - clears on any I grant, or when i_req = 0.
- Response register: owner <= I on an I grant; D on a load grant; NONE otherwise (stores and idle).
- Read data (cycle after grant, 1-cycle latency):
  - i_rvalid = (owner == I); d_rvalid = (owner == D).
  - The owner's rdata output = mem_rdata; the other port's rdata holds its last value.
- Back-to-back grants (throughput 1/cycle) are legal. A response and a new grant may overlap in the same cycle.
- Requester changing addr/we/wdata while req = 1 and not granted is legal; values are sampled only at the grant cycle.
- Store followed by a load to the same word on the next cycle returns the new data (memory is write-first per cycle ordering).

Optional Feature:
- Macro: MEM_ARB_ALIGN_CHECK_EN.
- With the macro:
  - A request whose addr[1:0] != 0 is still granted (gnt = 1), but mem_en is forced to 0.
  - One cycle later, the matching rvalid (for loads/fetch) pulses with rdata = 32'hDEADBEEF.
  - Added output port align_err (1-bit), which pulses the same cycle as that response (stores included); reset value 0.
- Without the macro: addr[1:0] are ignored, no align_err port exists, and all accesses reach memory.

Test Plan:
- Reset: hold reset 2 cycles with i_req = d_req = 1 → all gnt/rvalid = 0 during reset; on release, first grant is D.
- Fetch only: i_req = 1, i_addr = 0x0,0x4,0x8 on consecutive cycles, memory word0/1/2 = E3A000AA/E3A01055/E3A020FF → i_gnt each cycle; i_rvalid with those words one cycle later each.
- Store/load: d_req, d_we = 1, d_addr = 0xFC, d_wdata = 0x12345678; next cycle load 0xFC → d_rvalid = 1, d_rdata = 0x12345678; no d_rvalid after the store.
- Starvation: i_req and d_req held high continuously, STARVE_MAX = 4 → grant pattern D,D,D,D,I repeating; i_rvalid exactly once per 5 cycles.
- Wrap: fetch i_addr = 0x200 (MEM_WORDS = 128) → mem_addr = 0, returns word0 = E3A000AA.
- MEM_ARB_ALIGN_CHECK_EN: load d_addr = 0x6 → d_gnt = 1, mem_en = 0, next cycle d_rvalid = 1, d_rdata = DEADBEEF, align_err = 1.
